// File: rtl/spike_fifo.sv
// spike_fifo
// ----------
// Single-clock FIFO that sits between the bus-side producer/consumer and
// the SNN core. The read port is first-word-fall-through: the word at the
// head of the queue is always visible on pop_data, and asserting pop
// consumes it. Occupancy, empty/full, the sticky error flags and the
// peak-occupancy watermark are all registers. The status register window
// reads them directly, so none of them has a combinational path from
// push, pop or clr_flags.
//
// Ports
//   clk        in   1      clock; all state changes on the rising edge
//   rst        in   1      synchronous active-high reset
//   push       in   1      write request
//   push_data  in   WIDTH  write data, captured when the push is accepted
//   pop        in   1      read request; consumes the word on pop_data
//   pop_data   out  WIDTH  head-of-queue word, zero while empty
//   count      out  CW     occupancy, 0..DEPTH
//   empty      out  1      count == 0
//   full       out  1      count == DEPTH
//   overflow   out  1      sticky: a push was dropped
//   underflow  out  1      sticky: a pop was issued while empty
//   max_count  out  CW     highest occupancy since reset / last clr_flags
//   clr_flags  in   1      clears overflow, underflow and max_count
module spike_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow,
  output logic [CW-1:0]    max_count,
  input  logic             clr_flags
);

  // Pointer width. DEPTH >= 2, so this is always at least one bit.
  localparam int PW = $clog2(DEPTH);

  localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);

  // Storage. This array has no reset. Empty is tracked through the count,
  // so stale entries are never observed.
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_empty;
  logic          r_full;
  logic          r_overflow;
  logic          r_underflow;
  logic [CW-1:0] r_max_count;

  logic          w_pop_ok;
  logic          w_push_ok;
  logic          w_overflow_evt;
  logic          w_underflow_evt;
  logic [CW-1:0] w_count_next;
  logic [CW-1:0] w_max_next;
  logic [PW-1:0] w_wr_ptr_inc;
  logic [PW-1:0] w_rd_ptr_inc;

  // ---------------------------------------------------------------------
  // Accept logic
  // ---------------------------------------------------------------------
  // A push into a full FIFO is still accepted when a pop frees a slot in
  // the same cycle. That case cannot corrupt data: when full, wr_ptr ==
  // rd_ptr, and the head word is read out in the same cycle that the
  // slot is overwritten.
  assign w_pop_ok        = pop && !r_empty;
  assign w_push_ok       = push && (!r_full || w_pop_ok);
  assign w_overflow_evt  = push && !w_push_ok;
  assign w_underflow_evt = pop && r_empty;

  // Explicit wrap at DEPTH-1. DEPTH need not be a power of two.
  assign w_wr_ptr_inc = (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PW'(1);
  assign w_rd_ptr_inc = (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PW'(1);

  always_comb begin
    w_count_next = r_count;
    if (w_push_ok && !w_pop_ok) begin
      w_count_next = r_count + CW'(1);
    end else if (w_pop_ok && !w_push_ok) begin
      w_count_next = r_count - CW'(1);
    end
  end

  // The watermark restarts from the post-update occupancy, not from zero.
  // A clear therefore never reports less than the occupancy the FIFO
  // actually has.
  always_comb begin
    w_max_next = r_max_count;
    if (clr_flags || (w_count_next > r_max_count)) begin
      w_max_next = w_count_next;
    end
  end

  // ---------------------------------------------------------------------
  // Storage write (no reset on the array)
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst && w_push_ok) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // ---------------------------------------------------------------------
  // Control and status state
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_empty     <= 1'b1;
      r_full      <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_max_count <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= w_wr_ptr_inc;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= w_rd_ptr_inc;
      end
      r_count     <= w_count_next;
      // empty/full are decoded from the next count so that they are
      // registered alongside it rather than decoded after the flop.
      r_empty     <= (w_count_next == '0);
      r_full      <= (w_count_next == CNT_FULL);
      // A new event in the same cycle as a clear leaves the flag set.
      r_overflow  <= (r_overflow  && !clr_flags) || w_overflow_evt;
      r_underflow <= (r_underflow && !clr_flags) || w_underflow_evt;
      r_max_count <= w_max_next;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  // The head word depends only on registered state, so it has no path
  // from push or pop.
  assign pop_data  = r_empty ? '0 : r_mem[r_rd_ptr];
  assign count     = r_count;
  assign empty     = r_empty;
  assign full      = r_full;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;
  assign max_count = r_max_count;

endmodule

// File: doc/spike_fifo.md
# spike_fifo

Synchronous single-clock FIFO used as the SoC's input FIFO and output FIFO between the bus-side producer/consumer and the SNN core. Each instance has a first-word-fall-through read port, registered occupancy count and empty/full flags, and sticky overflow/underflow error flags. It also keeps a peak-occupancy watermark. Count and flags feed the read-only FIFO status register window at 0x4000_0400 directly.

## Interface

Parameters:
- WIDTH, 32: data word width in bits.
- DEPTH, 16: number of entries. Any value ≥ 2; not restricted to powers of two. Instances use snn_soc_pkg::INPUT_FIFO_DEPTH and snn_soc_pkg::OUTPUT_FIFO_DEPTH.
- CW, $clog2(DEPTH+1): count width (derived; do not override).

Ports:
- Clock and reset (already decided): one clock; reset is synchronous and active-high.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- push  in  1  write request.
- push_data  in  WIDTH  write data, sampled when push is accepted.
- pop  in  1  read request; consumes the word currently on pop_data.
- pop_data  out  WIDTH  head-of-queue word; all zeros when empty.
- count  out  CW  current occupancy, 0..DEPTH.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- overflow  out  1  sticky: a push was dropped.
- underflow  out  1  sticky: a pop was issued while empty.
- max_count  out  CW  highest count reached since reset or the last clr_flags.
- clr_flags  in  1  clears overflow, underflow and max_count.

## Operation

- Storage: DEPTH×WIDTH register array, wr_ptr and rd_ptr in range 0..DEPTH-1.
  - A pointer at DEPTH-1 wraps explicitly to 0. No power-of-two wrap is assumed.
  - The array is not reset.
- Push accepted when push && (!full || pop_ok).
  - pop_ok = pop && !empty.
  - On accept: write mem[wr_ptr] ← push_data, then advance wr_ptr.
- Pop accepted when pop && !empty: advance rd_ptr.
- Count update:
  - +1 on push-only accept.
  - −1 on pop-only accept.
  - Unchanged when both are accepted or neither is.
- Full with push and pop in the same cycle: both accepted, count stays DEPTH, no overflow.
- Empty with push and pop in the same cycle: push accepted, pop rejected, underflow sets, count → 1.
- Full with push and no pop: push dropped, overflow sets, contents unchanged.
- Empty with pop and no push: underflow sets, pointers unchanged.
- pop_data = mem[rd_ptr] when !empty, else 0. Combinational from registered state only; no path from push/pop.
- empty and full are registered, computed from next count. They are never decoded combinationally from the inputs.
- Sticky flags: set on their event, cleared only by rst or clr_flags. If clr_flags and a new event fall in the same cycle, the event wins and the flag ends at 1.
- max_count ← max(max_count, next count) every cycle.
  - On clr_flags: max_count ← next count, not 0.

## Timing

- Reset values: count 0, empty 1, full 0, overflow 0, underflow 0, max_count 0, pop_data 0, both pointers 0.
- Write-to-read latency is 1 cycle:
  - Push accepted at edge N into an empty FIFO.
  - From edge N: empty = 0, count = 1, pop_data = that word.
- Pop at edge N: the next word (or 0) appears on pop_data after edge N.
- A pop is issued combinationally from the pop_data seen in the same cycle (first-word-fall-through).
- Any rst cycle overrides all other inputs; push and pop in that cycle are ignored.
- Reset mid-operation discards all contents. After reset: empty = 1, and no flags are set by the discarded data.
- All outputs change only after a rising clk edge.
- There are no combinational paths from push, pop or clr_flags to any output.

## Test plan

- Reset then idle → count 0, empty 1, full 0, pop_data 0, overflow/underflow/max_count 0.
- DEPTH=5: push 0xA0..0xA4 → full 1, count 5. Then pop 5 times → data A0..A4 in order, empty 1. Then push/pop 12 more words, crossing the index 4→0 wrap twice → order preserved.
- Fill to full, push 0xDEAD without pop → overflow 1, count 5, 0xDEAD never read. Next, push+pop in the same cycle while full → count 5, overflow unchanged, order preserved.
- Empty, pop → underflow 1. Next, push 0x55 and pop in the same cycle while empty → count 1, pop_data 0x55.
- Reach count 4, pop to 1 → max_count 4. clr_flags with a same-cycle push → max_count 2, flags 0. Overflow event in the same cycle as clr_flags → overflow 1.
- Assert rst with 3 entries held and push=1 → count 0, empty 1, flags 0. First push after reset is read back correctly.
